// File: rtl/p_fadd_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : p_fadd_sub_pkg
// Brief    : Shared constants and stage-register types for p_fadd_sub.
// Revision : 1.0
// ============================================================================
package p_fadd_sub_pkg;

    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 2 * BIAS + 1;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    // Significands carry {24-bit mantissa, guard, round, sticky}.
    typedef struct packed {
        logic        special;
        logic [31:0] spec_val;
        logic        sign_l;
        logic        eff_sub;
        logic [7:0]  exp_l;
        logic [26:0] mant_l;
        logic [26:0] mant_s;
    } s1_t;

    typedef struct packed {
        logic        special;
        logic [31:0] spec_val;
        logic        sign_l;
        logic        eff_sub;
        logic [7:0]  exp_l;
        logic [27:0] sum;
        logic [4:0]  lz;
    } s2_t;

    typedef struct packed {
        logic [31:0] res;
        logic        overflow;
        logic        underflow;
    } s3_t;

endpackage
`default_nettype wire

// File: rtl/p_fadd_sub_lzc24.sv
`default_nettype none
// ============================================================================
// Module   : lzc24
// Brief    : Combinational 24-bit leading-zero counter (24 when input is 0).
// Revision : 1.0
// ============================================================================
module lzc24 (
    input  logic [23:0] d_i,
    output logic [4:0]  cnt_o
);

    // Ascending scan: the highest set bit is the last to write the count.
    always_comb begin
        cnt_o = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (d_i[i]) begin
                cnt_o = 5'(23 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/p_fadd_sub.sv
`default_nettype none
// ============================================================================
// Module   : p_fadd_sub
// Brief    : 3-stage pipelined IEEE-754 binary32 adder/subtractor, RNE.
// Revision : 1.0
// ============================================================================
module p_fadd_sub
    import p_fadd_sub_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        op,
    output logic [31:0] out,
    output logic        overflow,
    output logic        underflow
);

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    // ---------------- S1: unpack, specials, swap, align ----------------
    logic [31:0] w_b, w_big, w_small;
    logic [7:0]  w_el, w_es, w_diff;
    logic [4:0]  w_shamt;
    logic [49:0] w_shw;
    logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b;

    always_comb begin
        w_b     = {in2[31] ^ op, in2[30:0]};
        w_nan_a = (in1[30:23] == 8'(EXP_MAX)) && (in1[22:0] != 23'd0);
        w_nan_b = (w_b[30:23] == 8'(EXP_MAX)) && (w_b[22:0] != 23'd0);
        w_inf_a = (in1[30:23] == 8'(EXP_MAX)) && (in1[22:0] == 23'd0);
        w_inf_b = (w_b[30:23] == 8'(EXP_MAX)) && (w_b[22:0] == 23'd0);

        // Raw magnitude compare orders subnormals correctly as well.
        if (in1[30:0] >= w_b[30:0]) begin
            w_big   = in1;
            w_small = w_b;
        end else begin
            w_big   = w_b;
            w_small = in1;
        end
        w_el    = (w_big[30:23] == 8'd0)   ? 8'd1 : w_big[30:23];
        w_es    = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
        w_diff  = w_el - w_es;
        w_shamt = (w_diff > 8'd26) ? 5'd26 : w_diff[4:0];
        w_shw   = {(w_small[30:23] != 8'd0), w_small[22:0], 26'd0} >> w_shamt;

        s1_d          = '0;
        s1_d.sign_l   = w_big[31];
        s1_d.eff_sub  = w_big[31] ^ w_small[31];
        s1_d.exp_l    = w_el;
        s1_d.mant_l   = {(w_big[30:23] != 8'd0), w_big[22:0], 3'b000};
        s1_d.mant_s   = {w_shw[49:24], |w_shw[23:0]};
        s1_d.special  = w_nan_a | w_nan_b | w_inf_a | w_inf_b;
        if (w_nan_a || w_nan_b) begin
            s1_d.spec_val = QNAN;
        end else if (w_inf_a && w_inf_b) begin
            s1_d.spec_val = (in1[31] != w_b[31]) ? QNAN : {in1[31], POS_INF[30:0]};
        end else if (w_inf_a) begin
            s1_d.spec_val = {in1[31], POS_INF[30:0]};
        end else begin
            s1_d.spec_val = {w_b[31], POS_INF[30:0]};
        end
    end

    // ---------------- S2: magnitude add/sub, leading zeros ----------------
    logic [27:0] w_sum;
    logic [4:0]  w_lz;

    always_comb begin
        w_sum = s1_q.eff_sub ? ({1'b0, s1_q.mant_l} - {1'b0, s1_q.mant_s})
                             : ({1'b0, s1_q.mant_l} + {1'b0, s1_q.mant_s});
    end

    lzc24 u_lzc (
        .d_i   (w_sum[26:3]),
        .cnt_o (w_lz)
    );

    always_comb begin
        s2_d          = '0;
        s2_d.special  = s1_q.special;
        s2_d.spec_val = s1_q.spec_val;
        s2_d.sign_l   = s1_q.sign_l;
        s2_d.eff_sub  = s1_q.eff_sub;
        s2_d.exp_l    = s1_q.exp_l;
        s2_d.sum      = w_sum;
        s2_d.lz       = w_lz;
    end

    // ---------------- S3: normalize, round, pack ----------------
    logic [7:0]  w_lim;
    logic [4:0]  w_sh;
    logic [26:0] w_mn;
    logic [9:0]  w_en, w_ebase, w_field;
    logic        w_rup;
    logic [24:0] w_rnd;
    logic [22:0] w_frac;

    always_comb begin
        w_lim = s2_q.exp_l - 8'd1;
        w_sh  = ({3'b000, s2_q.lz} > w_lim) ? w_lim[4:0] : s2_q.lz;
        if (s2_q.sum[27]) begin
            w_mn = {s2_q.sum[27:2], s2_q.sum[1] | s2_q.sum[0]};
            w_en = {2'b00, s2_q.exp_l} + 10'd1;
        end else begin
            w_mn = s2_q.sum[26:0] << w_sh;
            w_en = {2'b00, s2_q.exp_l} - {5'd0, w_sh};
        end
        // Hidden bit still clear after the limited shift means subnormal.
        w_ebase = w_mn[26] ? w_en : 10'd0;
        w_rup   = w_mn[2] & (w_mn[1] | w_mn[0] | w_mn[3]);
        w_rnd   = {1'b0, w_mn[26:3]} + {24'd0, w_rup};
        if (w_rnd[24]) begin
            w_field = w_ebase + 10'd1;
            w_frac  = 23'd0;
        end else begin
            w_field = ((w_ebase == 10'd0) && w_rnd[23]) ? 10'd1 : w_ebase;
            w_frac  = w_rnd[22:0];
        end

        s3_d = '0;
        if (s2_q.special) begin
            s3_d.res = s2_q.spec_val;
        end else if (s2_q.sum == 28'd0) begin
            s3_d.res = {~s2_q.eff_sub & s2_q.sign_l, 31'd0};
        end else if (w_field >= 10'(EXP_MAX)) begin
            s3_d.res      = {s2_q.sign_l, POS_INF[30:0]};
            s3_d.overflow = 1'b1;
        end else begin
            s3_d.res       = {s2_q.sign_l, w_field[7:0], w_frac};
            s3_d.underflow = (w_field == 10'd0) && (w_frac != 23'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else if (en) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign out       = s3_q.res;
    assign overflow  = s3_q.overflow;
    assign underflow = s3_q.underflow;

endmodule
`default_nettype wire

// File: tb/tb_p_fadd_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_p_fadd_sub
// Brief    : Directed scoreboard testbench for p_fadd_sub.
// Revision : 1.0
// ============================================================================
module tb_p_fadd_sub;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        op;
    logic [31:0] out;
    logic        overflow;
    logic        underflow;

    int          vectors;
    int          miscompares;
    logic [33:0] exq[$];
    string       tagq[$];
    logic [2:0]  pipe;
    logic [33:0] last_exp;

    p_fadd_sub dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .out       (out),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] r(input logic [31:0] o, input logic v, input logic u);
        return {o, v, u};
    endfunction

    task automatic check(input string tag, input logic [33:0] expv);
        vectors++;
        assert ({out, overflow, underflow} === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h", tag, {out, overflow, underflow}, expv);
        end
    endtask

    // One clock edge; pushes the expected result when a vector is launched
    // and compares the entry that reaches the output two edges later.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic o,
                        input logic e, input logic push, input logic [33:0] expv,
                        input string tag);
        logic [33:0] ev;
        string       t;
        in1 = a;
        in2 = b;
        op  = o;
        en  = e;
        if (push && e) begin
            exq.push_back(expv);
            tagq.push_back(tag);
        end
        @(posedge clk);
        #1;
        if (e) begin
            pipe = {pipe[1:0], push};
            if (pipe[2]) begin
                if (exq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL scoreboard: observed a result, queue empty");
                end else begin
                    ev = exq.pop_front();
                    t  = tagq.pop_front();
                    last_exp = ev;
                    check(t, ev);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pipe        = 3'b000;
        last_exp    = '0;
        rst = 1'b1;
        en  = 1'b0;
        in1 = 32'h0;
        in2 = 32'h0;
        op  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", r(32'h0, 1'b0, 1'b0));
        rst = 1'b0;

        step(32'h3C600011, 32'hBE820000, 1'b0, 1'b1, 1'b1, r(32'hBE75FFFF, 0, 0), "mixed_add");
        step(32'h007FFFFF, 32'h007FFFFF, 1'b0, 1'b1, 1'b1, r(32'h00FFFFFE, 0, 0), "sub_sub_norm");
        step(32'h00C00000, 32'h00400000, 1'b1, 1'b1, 1'b1, r(32'h00800000, 0, 0), "sub_to_min_norm");
        step(32'h00C00000, 32'h00800000, 1'b1, 1'b1, 1'b1, r(32'h00400000, 0, 1), "sub_to_subnorm");
        step(32'h7F800000, 32'h7F800000, 1'b0, 1'b1, 1'b1, r(32'h7F800000, 0, 0), "inf_plus_inf");
        step(32'h7F800000, 32'h7F800000, 1'b1, 1'b1, 1'b1, r(32'h7FC00000, 0, 0), "inf_minus_inf");
        step(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 1'b1, r(32'h7F800000, 1, 0), "max_plus_max");
        step(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 1'b1, 1'b1, r(32'h00000000, 0, 0), "max_minus_max");

        // Two stalled edges with garbage inputs: output must not move.
        step(32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0, 1'b0, '0, "stall");
        check("freeze1", last_exp);
        step(32'hCAFEF00D, 32'h3F800000, 1'b0, 1'b0, 1'b0, '0, "stall");
        check("freeze2", last_exp);

        step(32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 1'b1, r(32'h40000000, 0, 0), "one_plus_one");
        step(32'h40000000, 32'h3F800000, 1'b1, 1'b1, 1'b1, r(32'h3F800000, 0, 0), "two_minus_one");
        step(32'h3F800000, 32'h3F800000, 1'b1, 1'b1, 1'b1, r(32'h00000000, 0, 0), "exact_cancel");
        step(32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b1, r(32'h80000000, 0, 0), "negz_plus_negz");
        step(32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1, r(32'h80000000, 0, 0), "negz_minus_posz");
        step(32'h00000000, 32'h80000000, 1'b0, 1'b1, 1'b1, r(32'h00000000, 0, 0), "posz_plus_negz");
        step(32'h7FC00001, 32'h3F800000, 1'b0, 1'b1, 1'b1, r(32'h7FC00000, 0, 0), "nan_in");
        step(32'hFF800000, 32'h3F800000, 1'b0, 1'b1, 1'b1, r(32'hFF800000, 0, 0), "neginf_plus_fin");
        step(32'h7F800000, 32'hFF800000, 1'b0, 1'b1, 1'b1, r(32'h7FC00000, 0, 0), "inf_plus_neginf");
        step(32'h3F800000, 32'h33800000, 1'b0, 1'b1, 1'b1, r(32'h3F800000, 0, 0), "tie_even_down");
        step(32'h3F800001, 32'h33800000, 1'b0, 1'b1, 1'b1, r(32'h3F800002, 0, 0), "tie_odd_up");
        step(32'h3F800000, 32'h33000000, 1'b1, 1'b1, 1'b1, r(32'h3F800000, 0, 0), "sub_tie_carry");
        step(32'h7F7FFFFF, 32'h73000000, 1'b0, 1'b1, 1'b1, r(32'h7F800000, 1, 0), "round_to_inf");

        // Reset pulse with operations in flight: cleared at once, then discarded.
        step(32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 1'b1, r(32'h40000000, 0, 0), "lost1");
        step(32'h40000000, 32'h40000000, 1'b0, 1'b1, 1'b1, r(32'h40800000, 0, 0), "lost2");
        #1 rst = 1'b1;
        #1 check("rst_mid", r(32'h0, 1'b0, 1'b0));
        exq.delete();
        tagq.delete();
        pipe = 3'b000;
        #1 rst = 1'b0;

        step(32'h40400000, 32'h3F800000, 1'b0, 1'b1, 1'b1, r(32'h40800000, 0, 0), "three_plus_one");
        step(32'hC0000000, 32'h3F800000, 1'b1, 1'b1, 1'b1, r(32'hC0400000, 0, 0), "neg2_minus_one");
        repeat (3) step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, '0, "bubble");

        vectors++;
        assert (exq.size() == 0)
        else begin
            miscompares++;
            $error("FAIL drain: observed %0d pending results, required 0", exq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/p_fadd_sub.md
P_FADD_SUB -- requirements
Module: p_fadd_sub

Interface
REQ-001 Parameters: none; format fixed to IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  pipeline advance enable; 0 = every stage register holds.
REQ-005 in1  input  32  operand A, binary32.
REQ-006 in2  input  32  operand B, binary32.
REQ-007 op  input  1  0 = A+B, 1 = A-B.
REQ-008 out  output  32  registered binary32 result.
REQ-009 overflow  output  1  registered; result overflowed to infinity.
REQ-010 underflow  output  1  registered; result is nonzero subnormal.

Function
REQ-011 The pipeline SHALL have 3 register stages:
- S1: unpack, specials detect, effective sign, align.
- S2: add/subtract magnitudes, leading-zero count.
- S3: normalize, round, pack.
REQ-012 Latency: operands/op sampled at rising edge N with en=1 SHALL appear on out/overflow/underflow after edge N+2; throughput is one operation per cycle.
REQ-013 With en=0 at an edge, no stage register SHALL change; outputs hold.
REQ-014 Subtraction SHALL be implemented as addition with in2 sign inverted.
REQ-015 Subnormal inputs SHALL be accepted: hidden bit 0, effective exponent 1.
REQ-016 Alignment SHALL right-shift the smaller-magnitude significand by the exponent difference, saturating at 26, keeping guard, round and sticky bits (sticky = OR of shifted-out bits).
REQ-017 Rounding SHALL be round-to-nearest, ties-to-even.
REQ-018 Normalization SHALL left-shift by the leading-zero count, limited so the exponent does not go below 1; if the result stays unnormalized, the exponent field SHALL be 0 (subnormal).
REQ-019 Exact zero from finite operands SHALL be +0, except (-0)+(-0) = -0.
REQ-020 Special cases:
- Any NaN operand -> out = 32'h7FC00000.
- +inf + -inf (effective) -> out = 32'h7FC00000.
- inf with finite operand -> that inf.
- inf + same-sign inf -> that inf.
- overflow=0 and underflow=0 in all these cases.
REQ-021 If a finite sum rounds to exponent >= 255, out SHALL be the signed infinity and overflow=1.
REQ-022 underflow SHALL be 1 only when the final out is a nonzero subnormal.
REQ-023 Flags SHALL be pipelined alongside out and be valid in the same cycle.

Reset
REQ-024 While rst=1, all stage registers SHALL clear asynchronously; out=32'h0, overflow=0, underflow=0.
REQ-025 Reset mid-operation SHALL discard all in-flight operations.
REQ-026 After rst deasserts, the first valid result SHALL appear 3 en=1 edges later.

Structure
REQ-027 A shared package SHALL hold:
- BIAS=127.
- EXP_MAX=255.
- QNAN=32'h7FC00000.
- POS_INF=32'h7F800000.
- Stage-register struct typedefs.
REQ-028 One sub-module SHALL be used: lzc24, a combinational 24-bit leading-zero counter with 5-bit output.

Verification
REQ-029 op=0, in1=3C600011, in2=BE820000 -> out=BE75FFFF, flags 0, 3 cycles later.
REQ-030 op=0, in1=in2=007FFFFF -> out=00FFFFFE, underflow=0.
REQ-031 op=1:
- in1=00C00000, in2=00400000 -> out=00800000, underflow=0.
- in1=00C00000, in2=00800000 -> out=00400000, underflow=1.
REQ-032 in1=in2=7F800000:
- op=0 -> out=7F800000, overflow=0.
- op=1 -> out=7FC00000.
REQ-033 in1=in2=7F7FFFFF:
- op=0 -> out=7F800000, overflow=1.
- op=1 -> out=00000000, flags 0.
REQ-034 Back-to-back operands every cycle:
- Each result SHALL emerge in order, one per cycle.
- Holding en=0 for 2 cycles freezes out.
- rst pulse mid-stream clears out to 0 immediately.
